// File: rtl/map_loader_if.sv
// map_loader_if: ROM bank bus between the map loader (master) and the map ROM bank (slave).
// Signals: rom_chipsel (map select) and rom_addr (row/point address) from the master;
// rom_data (registered read data) from the slave.
interface map_loader_if;
   logic [1:0] rom_chipsel;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   modport master (output rom_chipsel, output rom_addr, input rom_data);
   modport slave (input rom_chipsel, input rom_addr, output rom_data);
endinterface

// File: rtl/map_loader.sv
// map_loader: loads one of three ROM mazes into local registers and serves cell queries.
// Ports: clk; rst_n (async, active-low); load_req/load_sel request map 0-2;
// rom (map_loader_if.master) drives rom_chipsel/rom_addr and receives rom_data;
// busy/done/err/map_valid report load status; start_row/start_col/end_row/end_col
// are the decoded points; q_row/q_col -> q_open/q_is_end is the combinational query port.
// Optional feature macro MAP_LOADER_CHECK_EN: reject maps whose start or end cell is closed.
module map_loader #(
   parameter int ROM_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_req,
   input  logic [1:0]   load_sel,
   map_loader_if.master rom,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         map_valid,
   output logic [2:0]   start_row,
   output logic [2:0]   start_col,
   output logic [2:0]   end_row,
   output logic [2:0]   end_col,
   input  logic [2:0]   q_row,
   input  logic [2:0]   q_col,
   output logic         q_open,
   output logic         q_is_end
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
   state_t state, state_d;
   logic [7:0] row [8];
   logic [ROM_LATENCY-1:0] vld;
   logic [3:0] tag [ROM_LATENCY];
   logic [3:0] cap_tag;
   logic accept, reject, cap, fin, chk_ok;
   assign accept = state == IDLE && load_req && load_sel != 2'd3;
   assign reject = state == IDLE && load_req && load_sel == 2'd3;
   assign cap = vld[ROM_LATENCY-1];
   assign cap_tag = tag[ROM_LATENCY-1];
   // The tag-9 capture is always the last one and always lands in DRAIN.
   assign fin = state == DRAIN && cap && cap_tag == 4'd9;
   assign busy = state == FETCH || state == DRAIN;
`ifdef MAP_LOADER_CHECK_EN
   // End point is still on rom_data this edge, so look it up from the bus directly.
   assign chk_ok = row[start_row][start_col] && row[rom.rom_data[5:3]][rom.rom_data[2:0]];
`else
   assign chk_ok = 1'b1;
`endif
   always_comb begin
      state_d = state;
      case (state)
         IDLE:  state_d = accept ? FETCH : IDLE;
         FETCH: state_d = rom.rom_addr == 4'd9 ? DRAIN : FETCH;
         DRAIN: state_d = fin ? DONE : DRAIN;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   // Valid/tag shift register: an address issued in FETCH reaches the last stage
   // exactly when its ROM data is on rom_data.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < ROM_LATENCY; i++) tag[i] <= '0;
         for (int i = 0; i < 8; i++) row[i] <= '0;
         {start_row, start_col, end_row, end_col} <= '0;
         rom.rom_chipsel <= '0;
         rom.rom_addr <= '0;
         done <= 1'b0;
         err <= 1'b0;
         map_valid <= 1'b0;
      end else begin
         vld[0] <= state == FETCH;
         tag[0] <= rom.rom_addr;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            tag[i] <= tag[i-1];
         end
         if (cap && !cap_tag[3]) row[cap_tag[2:0]] <= rom.rom_data;
         if (cap && cap_tag == 4'd8) {start_row, start_col} <= rom.rom_data[5:0];
         if (fin) {end_row, end_col} <= rom.rom_data[5:0];
         if (accept) rom.rom_chipsel <= load_sel;
         rom.rom_addr <= state == FETCH && rom.rom_addr != 4'd9 ? rom.rom_addr + 4'd1 : 4'd0;
         done <= fin && chk_ok;
         err <= reject || (fin && !chk_ok);
         map_valid <= accept ? 1'b0 : map_valid || (fin && chk_ok);
      end
   assign q_open = map_valid && row[q_row][q_col];
   assign q_is_end = map_valid && q_row == end_row && q_col == end_col;
endmodule

// File: tb/tb_map_loader.sv
// tb_map_loader: table-driven directed bench for map_loader with a registered ROM model.
module tb_map_loader;
   localparam int L = 2;
   logic clk = 1'b0, rst_n = 1'b0, load_req = 1'b0;
   logic [1:0] load_sel = 2'd0;
   logic busy, done, err, map_valid, q_open, q_is_end;
   logic [2:0] start_row, start_col, end_row, end_col;
   logic [2:0] q_row = 3'd0, q_col = 3'd0;
   int checks = 0, failures = 0, overlap = 0;
   map_loader_if bus ();
   map_loader #(.ROM_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_sel(load_sel), .rom(bus),
      .busy(busy), .done(done), .err(err), .map_valid(map_valid),
      .start_row(start_row), .start_col(start_col), .end_row(end_row), .end_col(end_col),
      .q_row(q_row), .q_col(q_col), .q_open(q_open), .q_is_end(q_is_end));
   always #5 clk = ~clk;
   logic [7:0] rom_mem [30];
   logic [7:0] pipe [L];
   always @(posedge clk) begin
      pipe[0] <= (bus.rom_chipsel == 2'd3 || bus.rom_addr > 4'd9) ? 8'h00 :
                 rom_mem[int'(bus.rom_chipsel) * 10 + int'(bus.rom_addr)];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.rom_data = pipe[L-1];
   always @(negedge clk) if (done && err) overlap++;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // se = {start_row, start_col, end_row, end_col}
   task automatic sweep(input string name, input int map, input logic mv, input logic [11:0] se);
      int bad = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            q_row = 3'(r);
            q_col = 3'(c);
            #1;
            if (q_open !== (mv & rom_mem[map*10+r][c])) bad++;
            if (q_is_end !== (mv && 3'(r) == se[5:3] && 3'(c) == se[2:0])) bad++;
         end
      chk(name, bad, 0);
   endtask
   task automatic run_load(input logic [1:0] sel, input logic [1:0] exp_cs, input int intr_cyc,
                           input int rst_cyc, output int done_cyc, output int done_n,
                           output int err_cyc, output int err_n, output int busy_n,
                           output int addr_bad, output int cs_bad, output int mv_c1);
      done_cyc = 0; done_n = 0; err_cyc = 0; err_n = 0; busy_n = 0;
      addr_bad = 0; cs_bad = 0; mv_c1 = 0;
      @(negedge clk);
      load_req = 1'b1;
      load_sel = sel;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         load_req = cyc == intr_cyc;
         if (cyc == intr_cyc) load_sel = 2'd2;
         if (cyc == rst_cyc) begin
            rst_n = 1'b0;
            #1;
            chk("reset_midload_outputs", int'({busy, done, err, map_valid, bus.rom_chipsel,
                bus.rom_addr, start_row, start_col, end_row, end_col}), 0);
         end
         if (rst_cyc != 0 && cyc == rst_cyc + 1) rst_n = 1'b1;
         if (done) begin done_n++; if (done_cyc == 0) done_cyc = cyc; end
         if (err) begin err_n++; if (err_cyc == 0) err_cyc = cyc; end
         if (busy) busy_n++;
         if (cyc == 1) mv_c1 = int'(map_valid);
         if (rst_cyc == 0 || cyc < rst_cyc) begin
            if (sel != 2'd3 && cyc <= 10 && int'(bus.rom_addr) != cyc - 1) addr_bad++;
            if (bus.rom_chipsel != exp_cs) cs_bad++;
         end
      end
   endtask
   typedef struct {
      logic [1:0]  sel;
      int          map;
      int          done_cyc;
      int          err_cyc;
      logic        mv1;
      logic        mv;
      logic [1:0]  cs;
      logic [11:0] se;
   } lvec_t;
   typedef struct {
      logic [2:0] r;
      logic [2:0] c;
      logic       open;
      logic       is_end;
   } qvec_t;
   lvec_t lv [4];
   qvec_t qv [8];
   initial begin
      int dc, dn, ec, en, bn, ab, cb, m1;
      logic [7:0] m0 [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h49, 8'hEA};
      logic [7:0] m1r [10] = '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF, 8'h00, 8'h3F};
      logic [7:0] m2 [10] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h07, 8'h00};
      for (int i = 0; i < 10; i++) begin
         rom_mem[i] = m0[i];
         rom_mem[10+i] = m1r[i];
         rom_mem[20+i] = m2[i];
      end
      lv[0] = '{2'd1, 1, 13, 0, 1'b0, 1'b1, 2'd1, {3'd0, 3'd0, 3'd7, 3'd7}};
      lv[1] = '{2'd3, 1, 0, 1, 1'b1, 1'b1, 2'd1, {3'd0, 3'd0, 3'd7, 3'd7}};
`ifdef MAP_LOADER_CHECK_EN
      lv[2] = '{2'd2, 2, 0, 13, 1'b0, 1'b0, 2'd2, {3'd0, 3'd7, 3'd0, 3'd0}};
`else
      lv[2] = '{2'd2, 2, 13, 0, 1'b0, 1'b1, 2'd2, {3'd0, 3'd7, 3'd0, 3'd0}};
`endif
      lv[3] = '{2'd0, 0, 13, 0, 1'b0, 1'b1, 2'd0, {3'd1, 3'd1, 3'd5, 3'd2}};
      qv[0] = '{3'd5, 3'd2, 1'b1, 1'b1};
      qv[1] = '{3'd0, 3'd0, 1'b1, 1'b0};
      qv[2] = '{3'd0, 3'd1, 1'b0, 1'b0};
      qv[3] = '{3'd7, 3'd7, 1'b1, 1'b0};
      qv[4] = '{3'd3, 3'd4, 1'b0, 1'b0};
      qv[5] = '{3'd1, 3'd1, 1'b1, 1'b0};
      qv[6] = '{3'd6, 3'd6, 1'b1, 1'b0};
      qv[7] = '{3'd6, 3'd7, 1'b0, 1'b0};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_outputs", int'({busy, done, err, map_valid, bus.rom_chipsel, bus.rom_addr,
          start_row, start_col, end_row, end_col}), 0);
      sweep("query_before_load", 0, 1'b0, 12'd0);
      for (int v = 0; v < 4; v++) begin
         run_load(lv[v].sel, lv[v].cs, 0, 0, dc, dn, ec, en, bn, ab, cb, m1);
         chk($sformatf("v%0d_done_cycle", v), dc, lv[v].done_cyc);
         chk($sformatf("v%0d_err_cycle", v), ec, lv[v].err_cyc);
         chk($sformatf("v%0d_pulse_count", v), dn + en, 1);
         chk($sformatf("v%0d_busy_cycles", v), bn, lv[v].sel != 2'd3 ? 12 : 0);
         chk($sformatf("v%0d_addr_seq", v), ab, 0);
         chk($sformatf("v%0d_chipsel", v), cb, 0);
         chk($sformatf("v%0d_map_valid_c1", v), m1, int'(lv[v].mv1));
         chk($sformatf("v%0d_map_valid", v), int'(map_valid), int'(lv[v].mv));
         chk($sformatf("v%0d_points", v), int'({start_row, start_col, end_row, end_col}), int'(lv[v].se));
         sweep($sformatf("v%0d_query_sweep", v), lv[v].map, lv[v].mv, lv[v].se);
      end
      foreach (qv[i]) begin
         q_row = qv[i].r;
         q_col = qv[i].c;
         #1;
         chk($sformatf("q%0d_open", i), int'(q_open), int'(qv[i].open));
         chk($sformatf("q%0d_is_end", i), int'(q_is_end), int'(qv[i].is_end));
      end
      run_load(2'd0, 2'd0, 4, 0, dc, dn, ec, en, bn, ab, cb, m1);
      chk("ignore_done_cycle", dc, 13);
      chk("ignore_done_count", dn, 1);
      chk("ignore_err_count", en, 0);
      chk("ignore_chipsel", cb, 0);
      chk("ignore_busy_cycles", bn, 12);
      sweep("ignore_query_sweep", 0, 1'b1, {3'd1, 3'd1, 3'd5, 3'd2});
      run_load(2'd1, 2'd1, 0, 6, dc, dn, ec, en, bn, ab, cb, m1);
      chk("rst_done_count", dn, 0);
      chk("rst_err_count", en, 0);
      chk("rst_addr_seq", ab, 0);
      chk("rst_map_valid", int'(map_valid), 0);
      chk("rst_busy_after", int'(busy), 0);
      sweep("rst_query_sweep", 0, 1'b0, 12'd0);
      chk("done_err_overlap", overlap, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/map_loader.md
# map_loader

Sequencing controller for the map ROM bank. On request it selects one of the three stored mazes, walks ROM addresses 0–9 in a pipelined burst, and captures the 8 wall rows and the start/end points into local registers. It then exposes the loaded maze to the game logic through a combinational cell-query port. It is the only master of the ROM bank's chip-select and address inputs.

## Interface
- `ROM_LATENCY`, default 2: cycles from the cycle an address is held on `rom_addr` to the clock edge at which the matching `rom_data` is sampled. Legal range 1–4.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_req` in 1: load request, sampled each edge.
- `load_sel` in 2: map to load (0–2); sampled together with `load_req`.
- `rom_chipsel` out 2: registered map select driven to the ROM bank.
- `rom_addr` out 4: registered ROM address.
- `rom_data` in 8: registered ROM read data.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse; load completed successfully.
- `err` out 1: one-cycle pulse; request rejected or map check failed.
- `map_valid` out 1: the loaded map registers hold a complete, accepted map.
- `start_row`, `start_col`, `end_row`, `end_col` out 3 each: decoded start and end points.
- `q_row`, `q_col` in 3 each: cell query coordinates.
- `q_open` out 1: combinational; 1 when the queried cell is open and `map_valid` is 1.
- `q_is_end` out 1: combinational; 1 when (`q_row`,`q_col`) equals the end point and `map_valid` is 1.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE
  - If `load_req` is 1 and `load_sel` is 3: pulse `err` in the next cycle and stay in IDLE. Map registers are untouched.
  - If `load_req` is 1 and `load_sel` is 0–2: accept the request. Clear `map_valid`, latch `rom_chipsel` = `load_sel`, set `rom_addr` = 0, go to FETCH.
- FETCH: increment `rom_addr` on each edge up to 9. When `rom_addr` is 9, go to DRAIN on the next edge.
- Capture pipeline
  - A valid/tag shift register of depth `ROM_LATENCY` tracks the address in flight.
  - Tag r (0–7) writes `row[r]` = `rom_data`. Bit c = 1 means cell (r,c) is open.
  - Tag 8 writes the start point: `start_row` = `rom_data[5:3]`, `start_col` = `rom_data[2:0]`.
  - Tag 9 writes the end point in the same format. Bits 7:6 are ignored.
- DRAIN: wait until the tag-9 capture has been performed, then go to DONE.
- DONE (one cycle): pulse `done`, set `map_valid`, return to IDLE.
- `load_req` is ignored while `busy` is 1. There is no queueing.
- `busy` = 1 in FETCH and DRAIN.
- `rom_chipsel` holds its value after a load completes. `rom_addr` returns to 0 in IDLE.
- Query port: `q_open` = `row[q_row][q_col]` AND `map_valid`.

## Timing
- Reset: all outputs 0, all row, start and end registers 0, state IDLE. Reset is asserted asynchronously and released on a clock edge.
- Reset asserted mid-load aborts the load. No `done` or `err` follows, and `map_valid` stays 0 after reset is released.
- With `load_req` sampled at the end of cycle 0:
  - `rom_addr` = k during cycle 1+k (k = 0–9).
  - Data for address k is sampled at the end of cycle 1+k+`ROM_LATENCY`.
  - `busy` is 1 in cycles 1 through 10+`ROM_LATENCY`.
  - `done` is 1 in cycle 11+`ROM_LATENCY` (cycle 13 at the default), and `map_valid` rises in that same cycle.
- A new request accepted while `map_valid` is 1 clears `map_valid` in the first FETCH cycle.
- `err` for `load_sel` = 3 appears in cycle 1.
- `done` and `err` are never 1 in the same cycle.

## Configuration
- `MAP_LOADER_CHECK_EN`: when defined, the DONE state also checks that both the start cell and the end cell are open.
  - Check fails: pulse `err` instead of `done`, and `map_valid` stays 0. Captured registers keep the loaded values.
  - Check passes: behaviour is as described under Operation.
- When undefined, the check logic is absent and every completed load pulses `done`.

## Test plan
- Load map 1 (rows 0xFF,0x81,…; start 0x00, end 0x3F), `ROM_LATENCY`=2 -> `rom_chipsel`=1, `rom_addr` 0–9 in cycles 1–10, `done` in cycle 13, `start_row`/`start_col`=0,0, `end_row`/`end_col`=7,7, row registers match.
- Request with `load_sel`=3 -> `err` in cycle 1, `busy` stays 0, `map_valid` unchanged.
- Pulse `load_req` with `load_sel`=2 while loading map 0 -> ignored; map 0 data loaded and `rom_chipsel` stays 0 throughout.
- Assert `rst_n`=0 during cycle 6 of a load -> all outputs 0 immediately; no `done` after release.
- Query every (r,c) after loading map 0 -> `q_open` matches the ROM bit. Query the end point -> `q_is_end`=1. All queries return 0 before any load.
- `MAP_LOADER_CHECK_EN` defined, map with a start byte pointing at a closed cell -> `err` in cycle 13, no `done`, `map_valid`=0.
